// File: rtl/ap_sram_ctrl.sv
`timescale 1ns/1ps
// ap_sram_ctrl
//   Sequences 32-bit CPU bus accesses onto a 16-bit asynchronous SRAM with an
//   18-bit halfword address. Each word access becomes two halfword strobes,
//   low half first. Every strobe lasts WAIT_CYCLES clock cycles and is
//   followed by one recovery cycle. This block is the only driver of the
//   SRAM pins.
//
// Parameters
//   WAIT_CYCLES  strobe length in cycles per halfword (>= 1; 0 stops elaboration)
//
// Ports
//   iCLK, iRESET_n            clock, asynchronous active-low reset
//   iREQUEST                  level request, held until oREADY is seen
//   iRW                       1 = read, 0 = write (sampled at accept)
//   iADDR[31:0]               byte address, bits [18:2] used (sampled at accept)
//   iDATA[31:0]               write data (sampled at accept)
//   oDATA[31:0]               registered read data, holds the last read value
//   oREADY                    access complete, held while iREQUEST stays high
//   oBUSY                     controller is not idle
//   oSRAM_A[17:0]             halfword address {addr[18:2], half}
//   ioSRAM_D[15:0]            SRAM data bus, driven only during write phases
//   oSRAM_CE_n/OE_n/WE_n      active-low SRAM strobes
//
// Build option
//   SRAM_BYTE_MASK_EN  adds iBYTE_EN[3:0], oSRAM_UB_n and oSRAM_LB_n so that a
//   write only stores the enabled bytes. Without it every write stores all
//   32 bits.

module ap_sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        iCLK,
  input  logic        iRESET_n,
  input  logic        iREQUEST,
  input  logic        iRW,
  input  logic [31:0] iADDR,
  input  logic [31:0] iDATA,
`ifdef SRAM_BYTE_MASK_EN
  input  logic [3:0]  iBYTE_EN,
  output logic        oSRAM_UB_n,
  output logic        oSRAM_LB_n,
`endif
  output logic [31:0] oDATA,
  output logic        oREADY,
  output logic        oBUSY,
  output logic [17:0] oSRAM_A,
  inout  wire  [15:0] ioSRAM_D,
  output logic        oSRAM_CE_n,
  output logic        oSRAM_OE_n,
  output logic        oSRAM_WE_n
);

  if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
    $error("ap_sram_ctrl: WAIT_CYCLES must be at least 1");
  end

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LO_STB,
    LO_REC,
    HI_STB,
    HI_REC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [16:0]      addr_q;
  logic [31:0]      data_q;
  logic             rw_q;
  logic             accept;
  logic             cap_lo, cap_hi;
  logic             drive_en;
  logic [15:0]      drive_data;

`ifdef SRAM_BYTE_MASK_EN
  logic [3:0]       be_q;
`endif

  // Only address bits [18:2] select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iADDR[31:19], iADDR[1:0]};

  // State, wait counter, request latch and read-data capture.
  always_ff @(posedge iCLK or negedge iRESET_n) begin
    if (!iRESET_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      oDATA   <= '0;
`ifdef SRAM_BYTE_MASK_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= iADDR[18:2];
        data_q <= iDATA;
        rw_q   <= iRW;
`ifdef SRAM_BYTE_MASK_EN
        be_q   <= iBYTE_EN;
`endif
      end
      // Capture on the edge that ends the strobe, while OE_n is still low.
      if (cap_lo) begin
        oDATA[15:0] <= ioSRAM_D;
      end
      if (cap_hi) begin
        oDATA[31:16] <= ioSRAM_D;
      end
    end
  end

  // Next-state logic. The counter counts remaining strobe cycles down to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    cap_lo  = 1'b0;
    cap_hi  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iREQUEST) begin
          accept  = 1'b1;
          cnt_d   = CNT_RELOAD;
          state_d = LO_STB;
        end
      end
      LO_STB: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cap_lo  = rw_q;
          state_d = LO_REC;
        end
      end
      LO_REC: begin
        cnt_d   = CNT_RELOAD;
        state_d = HI_STB;
      end
      HI_STB: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cap_hi  = rw_q;
          state_d = HI_REC;
        end
      end
      HI_REC: begin
        state_d = DONE;
      end
      DONE: begin
        // Four-phase handshake: leave only once the request is withdrawn.
        if (!iREQUEST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM pin decode from registered state only, so reset idles the pins
  // immediately and no system input reaches the pins combinationally.
  // Recovery cycles keep the address and write data stable for hold time.
  always_comb begin
    oSRAM_CE_n = 1'b1;
    oSRAM_OE_n = 1'b1;
    oSRAM_WE_n = 1'b1;
    oSRAM_A    = '0;
    drive_en   = 1'b0;
    drive_data = '0;
`ifdef SRAM_BYTE_MASK_EN
    oSRAM_LB_n = 1'b1;
    oSRAM_UB_n = 1'b1;
`endif
    unique case (state_q)
      LO_STB, LO_REC: begin
        oSRAM_A    = {addr_q, 1'b0};
        drive_en   = !rw_q;
        drive_data = data_q[15:0];
        if (state_q == LO_STB) begin
          oSRAM_CE_n = 1'b0;
          oSRAM_OE_n = !rw_q;
          oSRAM_WE_n = rw_q;
        end
`ifdef SRAM_BYTE_MASK_EN
        if (rw_q) begin
          oSRAM_LB_n = (state_q != LO_STB);
          oSRAM_UB_n = (state_q != LO_STB);
        end else begin
          oSRAM_LB_n = !be_q[0];
          oSRAM_UB_n = !be_q[1];
        end
`endif
      end
      HI_STB, HI_REC: begin
        oSRAM_A    = {addr_q, 1'b1};
        drive_en   = !rw_q;
        drive_data = data_q[31:16];
        if (state_q == HI_STB) begin
          oSRAM_CE_n = 1'b0;
          oSRAM_OE_n = !rw_q;
          oSRAM_WE_n = rw_q;
        end
`ifdef SRAM_BYTE_MASK_EN
        if (rw_q) begin
          oSRAM_LB_n = (state_q != HI_STB);
          oSRAM_UB_n = (state_q != HI_STB);
        end else begin
          oSRAM_LB_n = !be_q[2];
          oSRAM_UB_n = !be_q[3];
        end
`endif
      end
      default: begin
      end
    endcase
  end

  assign ioSRAM_D = drive_en ? drive_data : 16'hzzzz;
  assign oREADY   = (state_q == DONE);
  assign oBUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_ap_sram_ctrl.sv
`timescale 1ns/1ps
// tb_ap_sram_ctrl
//   Two controller instances, lane 0 with WAIT_CYCLES=1 and lane 1 with
//   WAIT_CYCLES=3, each on its own behavioural SRAM. A transaction-level model
//   per lane predicts the pins and outputs from the number of edges since the
//   request was accepted. When nobody should drive the data bus the bench
//   places a sentinel value on it, so a stray controller drive shows up.

module tb_ap_sram_ctrl;

  localparam logic [15:0] SENT = 16'hA5C3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        rw    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        busy  [2];
  logic [17:0] sa    [2];
  logic        ce_n  [2];
  logic        oe_n  [2];
  logic        we_n  [2];
`ifdef SRAM_BYTE_MASK_EN
  logic [3:0]  be    [2];
  logic        ub_n  [2];
  logic        lb_n  [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int W = (g == 0) ? 1 : 3;

    wire  [15:0] sd;
    logic [15:0] mem    [0:255];
    logic [15:0] shadow [0:255];

    bit          m_act  = 1'b0;
    bit          m_done = 1'b0;
    bit          m_rw   = 1'b0;
    int          m_k    = 0;
    logic [16:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_rdata = '0;
    logic [3:0]  m_be   = 4'hF;
    logic [7:0]  hidx;
    logic [15:0] wh;
    logic [1:0]  hbe;
    bit          hi;

    bit          e_lo_stb, e_lo_rec, e_hi_stb, e_hi_rec, e_lo, e_hi, e_stb;
    logic [17:0] e_a;

    ap_sram_ctrl #(.WAIT_CYCLES(W)) dut (
      .iCLK       (clk),
      .iRESET_n   (rst_n),
      .iREQUEST   (req[g]),
      .iRW        (rw[g]),
      .iADDR      (addr[g]),
      .iDATA      (wdata[g]),
`ifdef SRAM_BYTE_MASK_EN
      .iBYTE_EN   (be[g]),
      .oSRAM_UB_n (ub_n[g]),
      .oSRAM_LB_n (lb_n[g]),
`endif
      .oDATA      (rdata[g]),
      .oREADY     (ready[g]),
      .oBUSY      (busy[g]),
      .oSRAM_A    (sa[g]),
      .ioSRAM_D   (sd),
      .oSRAM_CE_n (ce_n[g]),
      .oSRAM_OE_n (oe_n[g]),
      .oSRAM_WE_n (we_n[g])
    );

    // SRAM read drive, and the sentinel whenever the bus should be released
    assign sd = (!ce_n[g] && !oe_n[g]) ? mem[sa[g][7:0]] : 16'hzzzz;
    assign sd = (!(m_act && !m_rw) && (ce_n[g] || oe_n[g])) ? SENT : 16'hzzzz;

    // Behavioural SRAM storage, written mid-cycle while CE_n and WE_n are low
    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
      forever begin
        @(negedge clk);
        if (!ce_n[g] && !we_n[g]) begin
`ifdef SRAM_BYTE_MASK_EN
          if (!lb_n[g]) mem[sa[g][7:0]][7:0]  = sd[7:0];
          if (!ub_n[g]) mem[sa[g][7:0]][15:8] = sd[15:8];
`else
          mem[sa[g][7:0]] = sd;
`endif
        end
      end
    end

    // Transaction model: m_k counts edges since the accepting edge.
    // Strobe halves end on edges W-1 (low) and 2W (high); done after 2W+2.
    initial begin
      for (int i = 0; i < 256; i++) shadow[i] = 16'hC000 | 16'(i);
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_act = 1'b0; m_done = 1'b0; m_k = 0; m_rdata = '0;
        end else if (m_act) begin
          if (m_k == W - 1 || m_k == 2 * W) begin
            hi   = (m_k == 2 * W);
            hidx = {m_addr[6:0], hi};
            if (m_rw) begin
              if (hi) m_rdata[31:16] = shadow[hidx];
              else    m_rdata[15:0]  = shadow[hidx];
            end else begin
              wh  = hi ? m_data[31:16] : m_data[15:0];
              hbe = hi ? m_be[3:2] : m_be[1:0];
              if (hbe[0]) shadow[hidx][7:0]  = wh[7:0];
              if (hbe[1]) shadow[hidx][15:8] = wh[15:8];
            end
          end
          m_k++;
          if (m_k == 2 * W + 2) begin
            m_act = 1'b0; m_done = 1'b1;
          end
        end else if (m_done) begin
          if (!req[g]) m_done = 1'b0;
        end else if (req[g]) begin
          m_act = 1'b1; m_k = 0; m_rw = rw[g];
          m_addr = addr[g][18:2]; m_data = wdata[g];
`ifdef SRAM_BYTE_MASK_EN
          m_be = be[g];
`else
          m_be = 4'hF;
`endif
        end
      end
    end

    // Per-cycle comparison against the model
    initial begin
      forever begin
        @(negedge clk);
        if (rst_n) begin
          e_lo_stb = m_act && (m_k < W);
          e_lo_rec = m_act && (m_k == W);
          e_hi_stb = m_act && (m_k > W) && (m_k <= 2 * W);
          e_hi_rec = m_act && (m_k == 2 * W + 1);
          e_lo  = e_lo_stb || e_lo_rec;
          e_hi  = e_hi_stb || e_hi_rec;
          e_stb = e_lo_stb || e_hi_stb;
          e_a   = e_lo ? {m_addr, 1'b0} : (e_hi ? {m_addr, 1'b1} : 18'h0);
          checkOutput($sformatf("L%0d ce_n", g), 32'(ce_n[g]), 32'(!e_stb));
          checkOutput($sformatf("L%0d oe_n", g), 32'(oe_n[g]), 32'(!(e_stb && m_rw)));
          checkOutput($sformatf("L%0d we_n", g), 32'(we_n[g]), 32'(!(e_stb && !m_rw)));
          checkOutput($sformatf("L%0d addr", g), 32'(sa[g]), 32'(e_a));
          checkOutput($sformatf("L%0d ready", g), 32'(ready[g]), 32'(m_done));
          checkOutput($sformatf("L%0d busy", g), 32'(busy[g]), 32'(m_act || m_done));
          checkOutput($sformatf("L%0d odata", g), rdata[g], m_rdata);
          if (m_act && !m_rw)
            checkOutput($sformatf("L%0d bus write", g), 32'(sd), 32'(e_lo ? m_data[15:0] : m_data[31:16]));
          else if (!(e_stb && m_rw))
            checkOutput($sformatf("L%0d bus released", g), 32'(sd), 32'(SENT));
`ifdef SRAM_BYTE_MASK_EN
          if (e_stb && m_rw) begin
            checkOutput($sformatf("L%0d lb_n", g), 32'(lb_n[g]), 32'd0);
            checkOutput($sformatf("L%0d ub_n", g), 32'(ub_n[g]), 32'd0);
          end else if (m_act && !m_rw) begin
            checkOutput($sformatf("L%0d lb_n", g), 32'(lb_n[g]), 32'(!(e_lo ? m_be[0] : m_be[2])));
            checkOutput($sformatf("L%0d ub_n", g), 32'(ub_n[g]), 32'(!(e_lo ? m_be[1] : m_be[3])));
          end else begin
            checkOutput($sformatf("L%0d lb_n", g), 32'(lb_n[g]), 32'd1);
            checkOutput($sformatf("L%0d ub_n", g), 32'(ub_n[g]), 32'd1);
          end
`endif
        end
      end
    end
  end

  // One full access: request, wait for oREADY (bounded), hold, release.
  // The request fields are scrambled after acceptance; they must be ignored.
  task automatic applyStimulus(input int ln, input logic r, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] b, input int hold,
                               output int lat, output int lo_cnt, output int hi_cnt,
                               output logic [31:0] got);
    int n;
    lat = -1; lo_cnt = 0; hi_cnt = 0; got = '0; n = 0;
    @(negedge clk);
    req[ln] = 1'b1; rw[ln] = r; addr[ln] = a; wdata[ln] = d;
`ifdef SRAM_BYTE_MASK_EN
    be[ln] = b;
`else
    if (b != 4'hF) $display("[TB] byte enables ignored in this build");
`endif
    while (!ready[ln] && n < 100) begin
      @(negedge clk);
      n++;
      if (!ready[ln] && !(r ? oe_n[ln] : we_n[ln])) begin
        if (sa[ln][0]) hi_cnt++;
        else           lo_cnt++;
      end
      if (n == 1) begin
        rw[ln] = !r; addr[ln] = ~a; wdata[ln] = ~d;
      end
    end
    checkOutput($sformatf("L%0d ready seen", ln), 32'(ready[ln]), 32'd1);
    if (ready[ln]) begin
      lat = n - 1;
      got = rdata[ln];
    end
    repeat (hold) @(negedge clk);
    req[ln] = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkIdlePins(input int ln, input logic [15:0] bus);
    checkOutput($sformatf("L%0d rst ce_n", ln), 32'(ce_n[ln]), 32'd1);
    checkOutput($sformatf("L%0d rst oe_n", ln), 32'(oe_n[ln]), 32'd1);
    checkOutput($sformatf("L%0d rst we_n", ln), 32'(we_n[ln]), 32'd1);
    checkOutput($sformatf("L%0d rst ready", ln), 32'(ready[ln]), 32'd0);
    checkOutput($sformatf("L%0d rst busy", ln), 32'(busy[ln]), 32'd0);
    checkOutput($sformatf("L%0d rst addr", ln), 32'(sa[ln]), 32'd0);
    checkOutput($sformatf("L%0d rst bus", ln), 32'(bus), 32'(SENT));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, lo_cnt, hi_cnt, rdy_cycles;
    logic [31:0] got;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
`ifdef SRAM_BYTE_MASK_EN
      be[i] = 4'hF;
`endif
    end

    #12;
    checkIdlePins(0, lane[0].sd);
    checkIdlePins(1, lane[1].sd);
    checkOutput("L0 rst odata", rdata[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // W=1 write 0xDEADBEEF @0x10
    applyStimulus(0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, lat, lo_cnt, hi_cnt, got);
    checkOutput("W1 write latency", 32'(lat), 32'd4);
    checkOutput("W1 write we lo cycles", 32'(lo_cnt), 32'd1);
    checkOutput("W1 write we hi cycles", 32'(hi_cnt), 32'd1);
    checkOutput("W1 mem[8]", 32'(lane[0].mem[8]), 32'h0000_BEEF);
    checkOutput("W1 mem[9]", 32'(lane[0].mem[9]), 32'h0000_DEAD);

    // W=1 read back; upper and lower address bits outside [18:2] are ignored
    applyStimulus(0, 1'b1, 32'hFFF8_0013, 32'h0, 4'hF, 0, lat, lo_cnt, hi_cnt, got);
    checkOutput("W1 read latency", 32'(lat), 32'd4);
    checkOutput("W1 read oe lo cycles", 32'(lo_cnt), 32'd1);
    checkOutput("W1 read oe hi cycles", 32'(hi_cnt), 32'd1);
    checkOutput("W1 read data", got, 32'hDEAD_BEEF);

    // W=3 read of untouched memory, request held 3 extra cycles
    applyStimulus(1, 1'b1, 32'h0000_0010, 32'h0, 4'hF, 3, lat, lo_cnt, hi_cnt, got);
    checkOutput("W3 read latency", 32'(lat), 32'd8);
    checkOutput("W3 read oe lo cycles", 32'(lo_cnt), 32'd3);
    checkOutput("W3 read oe hi cycles", 32'(hi_cnt), 32'd3);
    checkOutput("W3 read data", got, 32'hC009_C008);
    repeat (2) @(negedge clk);
    checkOutput("W3 single access", 32'(busy[1]), 32'd0);

    // W=3 write
    applyStimulus(1, 1'b0, 32'h0000_0024, 32'hCAFE_F00D, 4'hF, 0, lat, lo_cnt, hi_cnt, got);
    checkOutput("W3 write latency", 32'(lat), 32'd8);
    checkOutput("W3 write we lo cycles", 32'(lo_cnt), 32'd3);
    checkOutput("W3 mem[18]", 32'(lane[1].mem[18]), 32'h0000_F00D);
    checkOutput("W3 mem[19]", 32'(lane[1].mem[19]), 32'h0000_CAFE);
    checkOutput("W3 odata kept", rdata[1], 32'hC009_C008);

    // Request dropped right after acceptance: access completes, oREADY one cycle
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 32'h30; wdata[0] = 32'h0BAD_F00D;
    @(negedge clk);
    req[0] = 1'b0;
    rdy_cycles = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready[0]) rdy_cycles++;
    end
    checkOutput("drop ready cycles", 32'(rdy_cycles), 32'd1);
    checkOutput("drop mem[24]", 32'(lane[0].mem[24]), 32'h0000_F00D);
    checkOutput("drop mem[25]", 32'(lane[0].mem[25]), 32'h0000_0BAD);

    // Reset pulse during the high strobe of a write
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 32'h40; wdata[0] = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre-reset we_n", 32'(we_n[0]), 32'd0);
    checkOutput("pre-reset addr", 32'(sa[0]), 32'h21);
    rst_n = 1'b0;
    #1;
    checkIdlePins(0, lane[0].sd);
    checkOutput("mid reset odata", rdata[0], 32'h0);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset mem[32]", 32'(lane[0].mem[32]), 32'h0000_5678);
    checkOutput("reset mem[33]", 32'(lane[0].mem[33]), 32'h0000_C021);
    applyStimulus(0, 1'b1, 32'h0000_0040, 32'h0, 4'hF, 0, lat, lo_cnt, hi_cnt, got);
    checkOutput("post-reset latency", 32'(lat), 32'd4);
    checkOutput("post-reset read", got, 32'hC021_5678);

`ifdef SRAM_BYTE_MASK_EN
    // Only byte 2 enabled: only the low byte of halfword 17 changes
    applyStimulus(0, 1'b0, 32'h0000_0020, 32'h1122_3344, 4'b0100, 0, lat, lo_cnt, hi_cnt, got);
    checkOutput("mask latency", 32'(lat), 32'd4);
    checkOutput("mask mem[16]", 32'(lane[0].mem[16]), 32'h0000_C010);
    checkOutput("mask mem[17]", 32'(lane[0].mem[17]), 32'h0000_C022);
    applyStimulus(0, 1'b1, 32'h0000_0020, 32'h0, 4'hF, 0, lat, lo_cnt, hi_cnt, got);
    checkOutput("mask read", got, 32'hC022_C010);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
